// File: rtl/montgomery_squarer_arbiter.sv
// Round-robin arbiter sharing one repeated-squaring Montgomery chain among NUM_REQ requesters:
// forwards the granted requester's base blocks, drops the chain's input echo, routes results back tagged.
module montgomery_squarer_arbiter #(
  parameter int REGISTER_SIZE     = 32,
  parameter int NUM_REQ           = 2,
  parameter int NUM_IN_BLOCKS     = 128,
  parameter int BLOCKS_PER_RESULT = 128,
  parameter int RESULTS_PER_JOB   = 2048,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ-1:0]               req_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0] data_in,
  input  logic [NUM_REQ-1:0]               data_valid_in,
  output logic [NUM_REQ-1:0]               grant_out,
  output logic                             sq_rst_out,
  output logic [REGISTER_SIZE-1:0]         sq_data_out,
  output logic                             sq_valid_out,
  input  logic [REGISTER_SIZE-1:0]         sq_block_in,
  input  logic                             sq_valid_in,
  output logic [REGISTER_SIZE-1:0]         result_out,
  output logic                             result_valid_out,
  output logic [IDW-1:0]                   result_id_out,
  output logic [NUM_REQ-1:0]               done_out
);

  localparam int TOTAL = BLOCKS_PER_RESULT * RESULTS_PER_JOB;
  localparam int OUTW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int INW   = $clog2(NUM_IN_BLOCKS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDW-1:0]      r_g, w_g_nxt, r_last, w_last_nxt, w_sel, w_idx;
  logic                w_sel_vld;
  logic [INW-1:0]      r_in_ctr, w_in_ctr_nxt;
  logic [OUTW-1:0]     r_out_ctr, w_out_ctr_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt, r_done, w_done_nxt;
  logic                r_sq_rst, w_sq_rst_nxt;
  logic                w_req_g, w_fwd_vld, w_res_vld;
  logic [REGISTER_SIZE-1:0] w_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_data[i] = data_in[i*REGISTER_SIZE +: REGISTER_SIZE];
  end

  assign w_req_g   = req_in[r_g];
  assign w_fwd_vld = (r_state == LOAD) && data_valid_in[r_g];
  // Results are only routed while the owner still holds its request; the abort cycle drops them.
  assign w_res_vld = (r_state == RUN) && w_req_g && sq_valid_in;

  assign sq_valid_out     = w_fwd_vld;
  assign sq_data_out      = (r_state == LOAD) ? w_data[r_g] : '0;
  assign result_valid_out = w_res_vld;
  assign result_out       = w_res_vld ? sq_block_in : '0;
  assign result_id_out    = w_res_vld ? r_g : '0;
  assign grant_out        = r_grant;
  assign sq_rst_out       = r_sq_rst;
  assign done_out         = r_done;

  // Scan from last_grant+1 with wraparound; descending loop lets the nearest requester win.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
      if (req_in[w_idx]) begin
        w_sel_vld = 1'b1;
        w_sel     = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_g_nxt       = r_g;
    w_last_nxt    = r_last;
    w_in_ctr_nxt  = r_in_ctr;
    w_out_ctr_nxt = r_out_ctr;
    w_grant_nxt   = r_grant;
    w_sq_rst_nxt  = 1'b0;
    w_done_nxt    = '0;
    if ((r_state == LOAD || r_state == RUN) && !w_req_g) begin
      w_state_nxt   = IDLE;
      w_grant_nxt   = '0;
      w_sq_rst_nxt  = 1'b1;
      w_last_nxt    = r_g;
      w_in_ctr_nxt  = '0;
      w_out_ctr_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_vld) begin
            w_state_nxt        = LOAD;
            w_g_nxt            = w_sel;
            w_grant_nxt        = '0;
            w_grant_nxt[w_sel] = 1'b1;
            w_sq_rst_nxt       = 1'b1;
            w_in_ctr_nxt       = '0;
            w_out_ctr_nxt      = '0;
          end
        end
        LOAD: begin
          if (w_fwd_vld) begin
            if (r_in_ctr == INW'(NUM_IN_BLOCKS - 1)) begin
              w_state_nxt  = RUN;
              w_in_ctr_nxt = '0;
            end else begin
              w_in_ctr_nxt = r_in_ctr + 1'b1;
            end
          end
        end
        RUN: begin
          if (w_res_vld) begin
            if (r_out_ctr == OUTW'(TOTAL - 1)) begin
              w_state_nxt      = DONE;
              w_grant_nxt      = '0;
              w_done_nxt[r_g]  = 1'b1;
              w_sq_rst_nxt     = 1'b1;
              w_last_nxt       = r_g;
              w_out_ctr_nxt    = '0;
              w_in_ctr_nxt     = '0;
            end else begin
              w_out_ctr_nxt = r_out_ctr + 1'b1;
            end
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_g       <= '0;
      r_last    <= IDW'(NUM_REQ - 1);
      r_in_ctr  <= '0;
      r_out_ctr <= '0;
      r_grant   <= '0;
      r_sq_rst  <= 1'b0;
      r_done    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_g       <= w_g_nxt;
      r_last    <= w_last_nxt;
      r_in_ctr  <= w_in_ctr_nxt;
      r_out_ctr <= w_out_ctr_nxt;
      r_grant   <= w_grant_nxt;
      r_sq_rst  <= w_sq_rst_nxt;
      r_done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_montgomery_squarer_arbiter.sv
// Bench for montgomery_squarer_arbiter: table and random jobs against a behavioural squarer and
// round-robin model, plus abort and asynchronous-reset sequences.
module tb_montgomery_squarer_arbiter;
  localparam int RS = 32, NR = 2, NIB = 4, BPR = 4, RPJ = 3, NRES = BPR * RPJ;

  typedef struct {
    logic [NR-1:0] req;
    int            stall;
    bit            junk;
    logic [NR-1:0] exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_in = '0;
  logic [NR-1:0]    data_valid_in = '0;
  logic [NR*RS-1:0] data_in = '0;
  logic [NR-1:0]    grant_out, done_out;
  logic             sq_rst_out, sq_valid_out, sq_valid_in, result_valid_out;
  logic [RS-1:0]    sq_data_out, sq_block_in, result_out;
  logic [0:0]       result_id_out;

  int errors = 0;
  int checks = 0;
  int stall_max = 0;
  logic          m_vld = 1'b0;
  logic [RS-1:0] m_dat = '0;
  int m_in = 0, m_emit = 0, m_gap = 0;

  always #5 clk = ~clk;

  montgomery_squarer_arbiter #(
    .REGISTER_SIZE(RS), .NUM_REQ(NR), .NUM_IN_BLOCKS(NIB),
    .BLOCKS_PER_RESULT(BPR), .RESULTS_PER_JOB(RPJ)
  ) dut (
    .clk_in(clk), .rst_in(rst), .req_in(req_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .grant_out(grant_out), .sq_rst_out(sq_rst_out),
    .sq_data_out(sq_data_out), .sq_valid_out(sq_valid_out), .sq_block_in(sq_block_in),
    .sq_valid_in(sq_valid_in), .result_out(result_out), .result_valid_out(result_valid_out),
    .result_id_out(result_id_out), .done_out(done_out)
  );

  // Squarer chain model: same-cycle echo of inputs, then NRES blocks 0xA0.. with random stalls.
  assign sq_valid_in = sq_valid_out | m_vld;
  assign sq_block_in = sq_valid_out ? sq_data_out : m_dat;

  always @(posedge clk) begin
    if (rst || sq_rst_out) begin
      m_in = 0; m_emit = 0; m_gap = 0;
    end
    if (!rst && sq_valid_out) begin
      m_in++;
      if (m_in == NIB) m_gap = int'($urandom_range(stall_max));
    end
    #1;
    m_vld = 1'b0;
    if (!rst && m_in >= NIB && m_emit < NRES) begin
      if (m_gap > 0) m_gap--;
      else begin
        m_vld  = 1'b1;
        m_dat  = RS'(32'hA0 + m_emit);
        m_emit++;
        m_gap  = int'($urandom_range(stall_max));
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] req, input int last);
    for (int k = 1; k <= NR; k++)
      if (req[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant_out, 0);
    check({tag, "_sq_rst"}, sq_rst_out, 0);
    check({tag, "_sq_valid"}, sq_valid_out, 0);
    check({tag, "_sq_data"}, sq_data_out, 0);
    check({tag, "_result"}, result_out, 0);
    check({tag, "_result_valid"}, result_valid_out, 0);
    check({tag, "_result_id"}, result_id_out, 0);
    check({tag, "_done"}, done_out, 0);
  endtask

  task automatic wait_grant(input logic [NR-1:0] exp, output int waited);
    waited = 0;
    while (grant_out == '0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("grant", grant_out, exp);
    check("grant_sq_rst", sq_rst_out, 1);
  endtask

  task automatic load_blocks(input int g, input bit junk);
    logic [RS-1:0] blk;
    for (int k = 0; k < NIB; k++) begin
      int gap;
      gap = (k == 0) ? 0 : int'($urandom_range(2));
      for (int s = 0; s <= gap; s++) begin
        blk = $urandom;
        data_in[g*RS +: RS]     = blk;
        data_in[(1-g)*RS +: RS] = 32'hDEAD;
        data_valid_in           = '0;
        data_valid_in[g]        = (s == gap);
        data_valid_in[1-g]      = junk && ($urandom_range(1) == 1);
        #1;
        check((s == gap) ? "fwd_valid" : "gap_no_fwd", sq_valid_out, (s == gap));
        if (s == gap) begin
          check("fwd_data", sq_data_out, blk);
          check("echo_hidden", result_valid_out, 0);
        end
        @(negedge clk);
        if (k == 0 && s == 0) check("sq_rst_one_cycle", sq_rst_out, 0);
      end
    end
    data_valid_in = '0;
  endtask

  task automatic collect_n(input int g, input int want);
    int got;
    got = 0;
    for (int c = 0; c < 200 && got < want; c++) begin
      if (result_valid_out) begin
        check("partial_data", result_out, 64'(32'hA0 + got));
        check("partial_id", result_id_out, 64'(g));
        got++;
      end
      if (got < want) @(negedge clk);
    end
    check("partial_count", got, want);
  endtask

  task automatic collect_to_done(input int g, input logic [NR-1:0] exp_done);
    int got, last, n;
    got = 0; last = -100;
    for (n = 0; n < 400; n++) begin
      if (result_valid_out) begin
        check("result_data", result_out, 64'(32'hA0 + got));
        check("result_id", result_id_out, 64'(g));
        got++;
        last = n;
      end
      if (done_out != '0) break;
      @(negedge clk);
    end
    check("done_pulse", done_out, exp_done);
    check("result_count", got, NRES);
    check("done_after_last", n - last, 1);
    check("done_grant_cleared", grant_out, 0);
    check("done_sq_rst", sq_rst_out, 1);
  endtask

  initial begin
    vec_t jobs[$];
    int waited, lm, g;
    jobs.push_back('{req: 2'b01, stall: 0, junk: 1'b0, exp_grant: 2'b01});
    jobs.push_back('{req: 2'b11, stall: 0, junk: 1'b1, exp_grant: 2'b10});
    jobs.push_back('{req: 2'b11, stall: 1, junk: 1'b0, exp_grant: 2'b01});
    jobs.push_back('{req: 2'b11, stall: 3, junk: 1'b1, exp_grant: 2'b10});
    jobs.push_back('{req: 2'b10, stall: 2, junk: 1'b0, exp_grant: 2'b10});
    jobs.push_back('{req: 2'b11, stall: 3, junk: 1'b1, exp_grant: 2'b01});
    lm = 0;
    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.req       = 2'($urandom_range(3, 1));
      g           = rr_pick(v.req, lm);
      v.exp_grant = 2'b01 << g;
      v.stall     = int'($urandom_range(3));
      v.junk      = ($urandom_range(1) == 1);
      jobs.push_back(v);
      lm = g;
    end

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    req_in = jobs[0].req;
    rst    = 1'b0;

    for (int i = 0; i < jobs.size(); i++) begin
      g = jobs[i].exp_grant[1] ? 1 : 0;
      stall_max = jobs[i].stall;
      wait_grant(jobs[i].exp_grant, waited);
      if (i > 0) check("regrant_gap", waited + 1, 2);
      load_blocks(g, jobs[i].junk);
      collect_to_done(g, jobs[i].exp_grant);
      req_in = (i + 1 < jobs.size()) ? jobs[i+1].req : '0;
      @(negedge clk);
      check("done_one_cycle", done_out, 0);
    end

    // Abort: requester 0 drops its request mid-RUN while requester 1 waits.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_in = 2'b01; stall_max = 0;
    wait_grant(2'b01, waited);
    load_blocks(0, 1'b0);
    collect_n(0, 5);
    @(negedge clk);
    req_in = 2'b10;
    #1;
    check("abort_cycle_drop", result_valid_out, 0);
    @(negedge clk);
    check("abort_grant_clear", grant_out, 0);
    check("abort_sq_rst", sq_rst_out, 1);
    check("abort_no_done", done_out, 0);
    check("abort_no_result", result_valid_out, 0);
    @(negedge clk);
    check("abort_regrant", grant_out, 2'b10);
    check("abort_regrant_rst", sq_rst_out, 1);
    load_blocks(1, 1'b1);
    collect_n(1, 3);

    // Asynchronous reset between edges while requester 1 is in RUN.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    req_in = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    wait_grant(2'b01, waited);
    req_in = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/montgomery_squarer_arbiter.md
Name: montgomery_squarer_arbiter

Overview:
Shares one repeated-squaring Montgomery stream (squarer + reducer chain) between NUM_REQ requesters.
- Grants the chain round-robin and forwards the granted requester's base blocks into it.
- Discards the chain's passthrough echo of those input blocks, then routes the squared result blocks back, tagged with the requester index.
- Resets the chain between jobs and signals job completion per requester.

Parameters:
REGISTER_SIZE, 32, width of one data block.
NUM_REQ, 2, number of requesters (≥2).
NUM_IN_BLOCKS, 128, base blocks per job forwarded into the squarer.
BLOCKS_PER_RESULT, 128, output blocks per reduced square.
RESULTS_PER_JOB, 2048, reduced squares emitted per job.

Ports:
clk_in  input  1  clock; all state updates on posedge.
rst_in  input  1  asynchronous, active-high reset.
req_in  input  NUM_REQ  per-requester job request; level, held for the whole job.
data_in  input  NUM_REQ*REGISTER_SIZE  per-requester base block; slice i belongs to requester i.
data_valid_in  input  NUM_REQ  per-requester block valid.
grant_out  output  NUM_REQ  one-hot grant, registered.
sq_rst_out  output  1  one-cycle reset pulse to the squarer chain.
sq_data_out  output  REGISTER_SIZE  block to the squarer.
sq_valid_out  output  1  squarer input valid.
sq_block_in  input  REGISTER_SIZE  squarer output block.
sq_valid_in  input  1  squarer output valid; it also echoes sq_valid_out blocks.
result_out  output  REGISTER_SIZE  routed result block.
result_valid_out  output  1  result block valid.
result_id_out  output  $clog2(NUM_REQ)  index of the requester owning result_out.
done_out  output  NUM_REQ  one-hot, one-cycle job-complete pulse.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; last_grant=NUM_REQ-1, so requester 0 wins first.
  - grant_out=0, sq_rst_out=0, sq_valid_out=0, sq_data_out=0, result_out=0, result_valid_out=0, result_id_out=0, done_out=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_in bit is set, select the first set bit scanning from last_grant+1 with wraparound.
  - Next cycle: grant_out=onehot(g), g registered, sq_rst_out=1 for exactly that cycle, state=LOAD.
  - If no request, stay in IDLE.
- LOAD:
  - Combinational passthrough: sq_data_out=data_in[g], sq_valid_out=data_valid_in[g].
  - data_valid_in of non-granted requesters is ignored (not forwarded, not counted).
  - in_ctr counts forwarded blocks. On the cycle the NUM_IN_BLOCKS-th block is forwarded, state=RUN next cycle.
  - sq_valid_in during LOAD is the chain's echo of the input: never routed, never counted.
- RUN:
  - sq_valid_out=0; data_valid_in is ignored.
  - Each sq_valid_in cycle: result_out=sq_block_in, result_valid_out=1, result_id_out=g (combinational, same cycle); out_ctr++.
  - When out_ctr reaches BLOCKS_PER_RESULT*RESULTS_PER_JOB−1 and sq_valid_in=1, state=DONE next cycle.
  - out_ctr width: $clog2(BLOCKS_PER_RESULT*RESULTS_PER_JOB).
- DONE (1 cycle):
  - done_out=onehot(g); grant_out=0; last_grant=g; sq_rst_out=1; counters cleared; state=IDLE next cycle.
  - A new grant can therefore issue no earlier than 2 cycles after the final result block.
- Abort: if req_in[g] drops during LOAD or RUN:
  - next cycle: state=IDLE, grant_out=0, sq_rst_out=1, counters cleared, no done_out, last_grant=g.
  - Any sq_valid_in in the abort cycle is dropped.
- Fairness:
  - A requester holding req_in is granted within NUM_REQ−1 jobs of other requesters.
  - Simultaneous requests resolve by the round-robin order above.
  - A request arriving while DONE is active is evaluated in IDLE on the next cycle.
- Outside RUN, result_valid_out=0 and result_out=0.
- Outside LOAD, sq_valid_out=0 and sq_data_out=0.
- rst_in asserted mid-job: immediate return to reset values. The chain is expected to share rst_in; sq_rst_out is not additionally pulsed.

Test Plan:
Configuration for all scenarios: NUM_REQ=2, NUM_IN_BLOCKS=4, BLOCKS_PER_RESULT=4, RESULTS_PER_JOB=3, with a behavioural squarer model that echoes inputs, then emits 12 blocks 0xA0..0xAB.
1. req_in=2'b01, blocks 0x1..0x4 → grant_out=01 with sq_rst_out pulse; 4 forwarded blocks; echoes not on result_valid_out; 12 results 0xA0..0xAB with id 0; done_out=01 one cycle after 0xAB.
2. req_in=2'b11 from reset → requester 0 served first, then requester 1 granted 2 cycles after done_out=01. A third back-to-back job with both requesting goes to requester 0 again.
3. During LOAD of requester 0, toggle data_valid_in[1] with data 0xDEAD → never appears on sq_data_out; in_ctr still needs 4 blocks from requester 0.
4. Drop req_in[0] after 5 RUN results → next cycle grant_out=0, sq_rst_out=1, no done_out; with requester 1 pending, it is granted next.
5. Assert rst_in asynchronously mid-RUN (between clock edges) → all outputs 0 before the next edge; after release requester 0 wins first.
6. Stall the squarer model (gaps of 0–3 cycles between sq_valid_in) → exactly 12 result blocks in order, done_out only after the 12th.
